// File: rtl/pellet_map_ctrl.sv
// Pellet map controller: owns the 32x32 pellet bitmap, reloads it from the layout ROM,
// serves renderer reads and game-logic eat requests, and tracks the remaining pellet count.
module pellet_map_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_fill,
    output logic [9:0] layout_addr,
    input  logic       layout_data,
    input  logic       render_rd,
    input  logic [4:0] render_x,
    input  logic [4:0] render_y,
    output logic       pellet_bit,
    input  logic       eat_req,
    input  logic [4:0] eat_x,
    input  logic [4:0] eat_y,
    output logic       eat_ack,
    output logic       eat_hit,
    output logic       eat_power,
    output logic [9:0] pellets_left,
    output logic       level_clear,
    output logic       busy,
    output logic       fill_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]  state_r;
    logic [10:0] fill_cnt_r;
    logic        map_r [0:1023];

    logic [9:0]  rd_addr_s;
    logic [9:0]  eat_addr_s;
    logic [9:0]  fill_wr_addr_s;
    logic        fill_wr_s;
    logic        eat_accept_s;
    logic        eat_old_s;

    function automatic logic is_power(input logic [4:0] x, input logic [4:0] y);
        return ((x == 5'd2) || (x == 5'd27)) && ((y == 5'd4) || (y == 5'd24));
    endfunction

    // ROM data lags its address by one cycle, so fill cycle k writes cell k-1
    assign rd_addr_s      = {render_y, render_x};
    assign eat_addr_s     = {eat_y, eat_x};
    assign fill_wr_addr_s = fill_cnt_r[9:0] - 10'd1;
    assign fill_wr_s      = (state_r == ST_FILL) && (fill_cnt_r != 11'd0);
    assign eat_accept_s   = (state_r == ST_RUN) && eat_req && !render_rd && !eat_ack && !start_fill;
    assign eat_old_s      = map_r[eat_addr_s];

    // State sequencing, fill address walk, arbitration and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            fill_cnt_r   <= 11'd0;
            layout_addr  <= 10'd0;
            pellet_bit   <= 1'b0;
            eat_ack      <= 1'b0;
            eat_hit      <= 1'b0;
            eat_power    <= 1'b0;
            pellets_left <= 10'd0;
            level_clear  <= 1'b0;
            busy         <= 1'b0;
            fill_done    <= 1'b0;
        end else begin
            fill_done   <= 1'b0;
            eat_ack     <= 1'b0;
            eat_hit     <= 1'b0;
            eat_power   <= 1'b0;
            level_clear <= 1'b0;
            if (render_rd) begin
                pellet_bit <= (state_r == ST_RUN) ? map_r[rd_addr_s] : 1'b0;
            end
            if (start_fill) begin
                state_r      <= ST_FILL;
                fill_cnt_r   <= 11'd0;
                layout_addr  <= 10'd0;
                pellets_left <= 10'd0;
                busy         <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_FILL: begin
                        if (fill_cnt_r == 11'd1024) begin
                            state_r   <= ST_RUN;
                            busy      <= 1'b0;
                            fill_done <= 1'b1;
                        end else begin
                            fill_cnt_r <= fill_cnt_r + 11'd1;
                            if (fill_cnt_r < 11'd1023) begin
                                layout_addr <= fill_cnt_r[9:0] + 10'd1;
                            end
                        end
                        // Saturate so a fully populated layout cannot wrap the count
                        if (fill_wr_s && layout_data && (pellets_left != 10'h3FF)) begin
                            pellets_left <= pellets_left + 10'd1;
                        end
                    end
                    ST_RUN: begin
                        if (eat_accept_s) begin
                            eat_ack   <= 1'b1;
                            eat_hit   <= eat_old_s;
                            eat_power <= eat_old_s & is_power(eat_x, eat_y);
                            if (eat_old_s && (pellets_left != 10'd0)) begin
                                pellets_left <= pellets_left - 10'd1;
                                level_clear  <= (pellets_left == 10'd1);
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Single-port map storage: fill writes and eat clears are mutually exclusive by state
    always_ff @(posedge clk) begin
        if (fill_wr_s) begin
            map_r[fill_wr_addr_s] <= layout_data;
        end else if (eat_accept_s) begin
            map_r[eat_addr_s] <= 1'b0;
        end
    end

endmodule

// File: doc/pellet_map_ctrl.md
# pellet_map_ctrl

Owns the 32x32 pellet map for the maze and sequences all access to it. Refills the map from the level layout ROM, serves per-cell reads to the pellet renderer, and services pellet-eat requests from game logic. Also maintains the remaining-pellet count and flags level clear. It sits between the layout ROM, the pellet renderer (cell bit input) and the player/game-state logic.

## Interface
- No parameters. Grid is fixed at 32x32 cells, 1 bit per cell, address {y[4:0], x[4:0]}.
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous reset, active low
- start_fill  in  1  one-cycle pulse: (re)load map from layout ROM
- layout_addr  out  10  layout ROM address {y,x}, registered
- layout_data  in  1  layout ROM bit, valid the cycle after layout_addr
- render_rd  in  1  renderer read strobe
- render_x, render_y  in  5 each  cell coordinates for the read
- pellet_bit  out  1  cell bit for the last accepted read
- eat_req  in  1  game logic requests clear of one cell
- eat_x, eat_y  in  5 each  cell to clear, held while eat_req is high
- eat_ack  out  1  one-cycle pulse: request serviced
- eat_hit  out  1  valid with eat_ack: cell held a pellet
- eat_power  out  1  valid with eat_ack: eat_hit and cell is a power pellet
- pellets_left  out  10  pellets remaining
- level_clear  out  1  one-cycle pulse when pellets_left reaches 0 through an eat
- busy  out  1  high while in FILL
- fill_done  out  1  one-cycle pulse at end of FILL

## Operation
- States: IDLE (after reset, map invalid), FILL, RUN.
- IDLE: pellet_bit forced 0 and eat_req never acked. Only start_fill → FILL.
- FILL:
  - Walks layout_addr 0..1023. Each bit is written into the map one cycle later.
  - pellets_left is cleared on entry and incremented for every 1 written.
  - Render reads return 0. eat_req is not acked (requester keeps holding it).
- When cell 1023 has been written, fill_done pulses and the state moves to RUN.
- start_fill in FILL restarts from address 0 with pellets_left cleared. start_fill in RUN → FILL.
- RUN arbitration: single map port, one access per cycle, render_rd has absolute priority.
  - An eat is accepted in a RUN cycle with eat_req=1, render_rd=0 and eat_ack=0.
  - Access is read-before-write: the old bit is captured and the cell is written to 0.
- Power-pellet cells: x∈{2,27} and y∈{4,24}.
- On an accepted eat with old bit 1:
  - pellets_left decrements.
  - If the result is 0, level_clear pulses together with eat_ack.
  - pellets_left never wraps: an eat on an empty cell leaves it unchanged.
- Reset mid-operation: immediate return to IDLE and all outputs go to reset values. Map contents are unspecified until the next fill completes.

## Timing
- Reset values: all outputs are 0, including layout_addr, pellets_left and busy. The state is IDLE.
- Render read: render_rd sampled at edge t → pellet_bit valid from t+1 and held until the next accepted read.
- Eat: request accepted at edge t.
  - eat_ack, eat_hit, eat_power and level_clear are high for exactly the cycle after t.
  - The map bit and pellets_left are updated at edge t.
  - A render read accepted at t+1 or later sees the cleared cell.
- Requester drops eat_req in the eat_ack cycle. eat_req held in that cycle is ignored.
- Fill: start_fill sampled at edge E.
  - busy rises after E.
  - layout_addr = k in the k-th cycle after E (k = 0..1023).
  - The map cell k is written at the end of cycle k+1.
  - fill_done is high in cycle 1025 after E, busy is low from cycle 1025, and the state is RUN from cycle 1025.
  - pellets_left is final in the fill_done cycle.

## Test plan
- Reset, then render_rd at (3,5) → pellet_bit=0, eat_req held 10 cycles → no eat_ack.
- Fill with a layout of 1s at exactly 244 cells → fill_done exactly 1025 cycles after start_fill, pellets_left=244, busy high throughout, and reads of set cells return 1.
- Eat (2,4) → eat_ack with hit=1, power=1, pellets_left=243. Eat (2,4) again → hit=0, count unchanged. Render read of (2,4) → 0.
- Hold render_rd high 20 cycles with eat_req pending → no ack during the burst. Ack comes one cycle after render_rd first drops; the pending eat is accepted at the first edge with render_rd low and acked in the cycle after.
- Layout with 1 pellet: eat it → eat_ack + level_clear same cycle, pellets_left=0. Eat an empty cell → no level_clear, count stays 0.
- start_fill at cycle 500 of a fill → restart from addr 0 with full 1025-cycle fill. reset_n low mid-fill → IDLE, all outputs 0.
